// File: rtl/key_conditioner_if.sv
// Pushbutton bundle between the raw KEY pins, the conditioner and its consumers.
// The conditioner uses the slave side; the stimulus/consumer side uses master.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_KEYS-1:0] KEY_LEVEL;
    logic [NUM_KEYS-1:0] PRESSED;
    logic [NUM_KEYS-1:0] RELEASED;
    logic [NUM_KEYS-1:0] REPEAT;

    modport master (
        output KEY,
        input  KEY_LEVEL,
        input  PRESSED,
        input  RELEASED,
        input  REPEAT
    );

    modport slave (
        input  KEY,
        output KEY_LEVEL,
        output PRESSED,
        output RELEASED,
        output REPEAT
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, stable-count debouncer, press/release pulses and
// optional hold-to-auto-repeat. Levels stay active-low like the raw pins.
module key_conditioner #(
    parameter int                  NUM_KEYS       = 4,
    parameter int                  DEBOUNCE_COUNT = 500000,
    parameter int                  REPEAT_DELAY   = 25000000,
    parameter int                  REPEAT_RATE    = 5000000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK    = 4'b0100,
    parameter int                  CNT_WIDTH      = 26
) (
    input  logic                    CLK,
    input  logic                    RESET,
    key_conditioner_if.slave        kif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RATE  = 2'd2
    } rep_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] DC_LAST  = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RR_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] w_released;
    logic [NUM_KEYS-1:0] w_repeat;

    assign kif.KEY_LEVEL = w_level;
    assign kif.PRESSED   = w_pressed;
    assign kif.RELEASED  = w_released;
    assign kif.REPEAT    = w_repeat;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic                 r_s1;
        logic                 r_s2;
        logic                 r_level;
        logic                 r_pressed;
        logic                 r_released;
        logic [CNT_WIDTH-1:0] r_dcnt;
        logic                 w_accept;
        logic                 w_press;
        logic                 w_release;

        assign w_accept  = (r_s2 != r_level) && (r_dcnt == DC_LAST);
        assign w_press   = w_accept & ~r_s2;
        assign w_release = w_accept &  r_s2;

        // Synchroniser, debounce counter, debounced level and edge pulses.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_s1       <= 1'b1;
                r_s2       <= 1'b1;
                r_level    <= 1'b1;
                r_pressed  <= 1'b0;
                r_released <= 1'b0;
                r_dcnt     <= CNT_ZERO;
            end else begin
                r_s1       <= kif.KEY[g];
                r_s2       <= r_s1;
                r_pressed  <= w_press;
                r_released <= w_release;
                if (r_s2 == r_level) begin
                    r_dcnt <= CNT_ZERO;
                end else if (w_accept) begin
                    r_level <= r_s2;
                    r_dcnt  <= CNT_ZERO;
                end else begin
                    r_dcnt <= r_dcnt + CNT_ONE;
                end
            end
        end

        assign w_level[g]    = r_level;
        assign w_pressed[g]  = r_pressed;
        assign w_released[g] = r_released;

        if (REPEAT_MASK[g]) begin : g_rep
            rep_state_t           r_state;
            rep_state_t           w_state_nxt;
            logic [CNT_WIDTH-1:0] r_rcnt;
            logic [CNT_WIDTH-1:0] w_rcnt_nxt;
            logic                 r_repeat;
            logic                 w_repeat_nxt;

            // Reset parks in DELAY: it only counts while the debounced level is
            // held low, so it behaves as IDLE until the next accepted press.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_state  <= ST_DELAY;
                    r_rcnt   <= CNT_ZERO;
                    r_repeat <= 1'b0;
                end else begin
                    r_state  <= w_state_nxt;
                    r_rcnt   <= w_rcnt_nxt;
                    r_repeat <= w_repeat_nxt;
                end
            end

            // Repeat next-state: release wins, then press, then timer phases.
            always_comb begin
                w_state_nxt  = r_state;
                w_rcnt_nxt   = r_rcnt;
                w_repeat_nxt = 1'b0;
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = CNT_ZERO;
                end else if (w_press) begin
                    w_state_nxt  = ST_DELAY;
                    w_rcnt_nxt   = CNT_ZERO;
                    w_repeat_nxt = 1'b1;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            w_rcnt_nxt = CNT_ZERO;
                        end
                        ST_DELAY: begin
                            if (r_level) begin
                                w_rcnt_nxt = CNT_ZERO;
                            end else if (r_rcnt == RD_LAST) begin
                                w_state_nxt  = ST_RATE;
                                w_rcnt_nxt   = CNT_ZERO;
                                w_repeat_nxt = 1'b1;
                            end else begin
                                w_rcnt_nxt = r_rcnt + CNT_ONE;
                            end
                        end
                        ST_RATE: begin
                            if (r_level) begin
                                w_state_nxt = ST_IDLE;
                                w_rcnt_nxt  = CNT_ZERO;
                            end else if (r_rcnt == RR_LAST) begin
                                w_rcnt_nxt   = CNT_ZERO;
                                w_repeat_nxt = 1'b1;
                            end else begin
                                w_rcnt_nxt = r_rcnt + CNT_ONE;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                            w_rcnt_nxt  = CNT_ZERO;
                        end
                    endcase
                end
            end

            assign w_repeat[g] = r_repeat;
        end else begin : g_norep
            assign w_repeat[g] = 1'b0;
        end
    end

endmodule
